// File: rtl/pipe_stage_reg.sv
// Handshaked pipeline stage register carrying an instruction word and its PC,
// with an optional 2-entry skid buffer that makes In_Ready a registered output.
module pipe_stage_reg #(
  parameter int unsigned       DATA_W    = 32,
  parameter int unsigned       PC_W      = 32,
  parameter logic [DATA_W-1:0] NOP_VALUE = {DATA_W{1'b0}},
  parameter bit                SKID      = 1'b1
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              Flush,
  input  logic              Stall,
  input  logic              In_Valid,
  output logic              In_Ready,
  input  logic [DATA_W-1:0] Instruction_in,
  input  logic [PC_W-1:0]   PC_in,
  output logic              Out_Valid,
  input  logic              Out_Ready,
  output logic [DATA_W-1:0] Instruction_out,
  output logic [PC_W-1:0]   PC_out,
  output logic [1:0]        Occupancy
);

  localparam int unsigned OCC_W = 2;

  typedef enum logic [1:0] {
    ST_EMPTY     = 2'd0,
    ST_FULL      = 2'd1,
    ST_SKID_FULL = 2'd2
  } state_t;

  state_t              r_state;
  logic                r_out_valid;
  logic                r_in_ready;
  logic [DATA_W-1:0]   r_instr;
  logic [PC_W-1:0]     r_pc;
  logic [DATA_W-1:0]   r_skid_instr;
  logic [PC_W-1:0]     r_skid_pc;
  logic [OCC_W-1:0]    r_occ;

  logic                w_accept;
  logic                w_pop;

  // Without the skid entry, readiness must look through to the downstream side.
  assign In_Ready = SKID ? r_in_ready : (!r_out_valid || (Out_Ready && !Stall));

  assign w_accept = In_Valid && In_Ready && !Flush;
  assign w_pop    = r_out_valid && Out_Ready && !Stall && !Flush;

  assign Out_Valid       = r_out_valid;
  assign Instruction_out = r_instr;
  assign PC_out          = r_pc;
  assign Occupancy       = r_occ;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_state      <= ST_EMPTY;
      r_out_valid  <= 1'b0;
      r_in_ready   <= 1'b1;
      r_instr      <= NOP_VALUE;
      r_pc         <= '0;
      r_skid_instr <= '0;
      r_skid_pc    <= '0;
      r_occ        <= OCC_W'(0);
    end else if (Flush) begin
      // Bubble: drop everything, but expose the flushing PC for redirect tracking.
      r_state     <= ST_EMPTY;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
      r_instr     <= NOP_VALUE;
      r_pc        <= PC_in;
      r_occ       <= OCC_W'(0);
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_accept) begin
            r_state     <= ST_FULL;
            r_out_valid <= 1'b1;
            r_instr     <= Instruction_in;
            r_pc        <= PC_in;
            r_occ       <= OCC_W'(1);
          end
        end
        ST_FULL: begin
          if (w_accept && w_pop) begin
            r_instr <= Instruction_in;
            r_pc    <= PC_in;
          end else if (w_accept && SKID) begin
            r_state      <= ST_SKID_FULL;
            r_skid_instr <= Instruction_in;
            r_skid_pc    <= PC_in;
            r_in_ready   <= 1'b0;
            r_occ        <= OCC_W'(2);
          end else if (w_pop) begin
            r_state     <= ST_EMPTY;
            r_out_valid <= 1'b0;
            r_instr     <= NOP_VALUE;
            r_occ       <= OCC_W'(0);
          end
        end
        ST_SKID_FULL: begin
          if (w_pop) begin
            r_state    <= ST_FULL;
            r_instr    <= r_skid_instr;
            r_pc       <= r_skid_pc;
            r_in_ready <= 1'b1;
            r_occ      <= OCC_W'(1);
          end
        end
        default: begin
          r_state     <= ST_EMPTY;
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
          r_instr     <= NOP_VALUE;
          r_occ       <= OCC_W'(0);
        end
      endcase
    end
  end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Parametrised, handshaked successor to the fixed 32-bit fetch/decode stage register. Usable at any pipeline boundary.
- Carries an instruction word and its PC between stages with a valid/ready handshake.
- Optional 2-entry skid buffer so `In_Ready` is registered. Flush inserts a bubble; `Stall` holds the stage.

Parameters:
- DATA_W, 32, instruction/payload width
- PC_W, 32, PC width
- NOP_VALUE, {DATA_W{1'b0}}, value driven on `Instruction_out` when the stage is empty or flushed
- SKID, 1, 1 = 2-entry skid buffer with registered `In_Ready`; 0 = single entry with combinational `In_Ready`

Ports:
- Clk  input  1  clock, all state updates on rising edge
- Rst_n  input  1  asynchronous active-low reset
- Flush  input  1  discard all held entries; dominates all other controls
- Stall  input  1  hold output; acts as `Out_Ready` = 0 for this stage
- In_Valid  input  1  upstream payload valid
- In_Ready  output  1  stage can accept this cycle
- Instruction_in  input  DATA_W  upstream instruction
- PC_in  input  PC_W  upstream PC
- Out_Valid  output  1  downstream payload valid
- Out_Ready  input  1  downstream accepts
- Instruction_out  output  DATA_W  held instruction (main entry)
- PC_out  output  PC_W  held PC (main entry)
- Occupancy  output  2  entries held: 0, 1 or 2

Behaviour:
- Reset (Rst_n = 0, asynchronous):
  - `Out_Valid` = 0, `Instruction_out` = NOP_VALUE, `PC_out` = 0, `Occupancy` = 0.
  - `In_Ready` = 1; skid entry invalid.
  - Reset asserted mid-transfer drops both entries with no partial update.
- Handshake terms:
  - `accept` = In_Valid & In_Ready & !Flush.
  - `pop` = Out_Valid & Out_Ready & !Stall & !Flush.
  - Payload stays stable while Out_Valid & !pop.
- State machine for SKID = 1 (states EMPTY, FULL, SKID_FULL):
  - EMPTY: accept -> FULL, main <= in. Latency is 1 cycle from input to `Out_Valid`.
  - FULL, accept & pop -> FULL, main <= in.
  - FULL, accept & !pop -> SKID_FULL, skid <= in, main unchanged.
  - FULL, !accept & pop -> EMPTY, `Instruction_out` <= NOP_VALUE, `PC_out` holds.
  - FULL, neither -> hold.
  - SKID_FULL: `In_Ready` = 0. pop -> FULL with main <= skid; otherwise hold.
  - `In_Ready` is registered: 1 in EMPTY and FULL, 0 in SKID_FULL. Never depends combinationally on `Out_Ready` or `Stall`.
- SKID = 0:
  - No SKID_FULL state.
  - `In_Ready` = !Out_Valid | (Out_Ready & !Stall), combinational.
  - accept & pop -> main <= in.
- Flush (any state):
  - Next edge: EMPTY, skid invalidated, `Out_Valid` = 0, `Instruction_out` = NOP_VALUE, `PC_out` <= PC_in, `Occupancy` = 0, `In_Ready` = 1.
  - Input present in the flush cycle is discarded.
  - Flush & Stall together -> flush wins.
- Stall:
  - No pop and no state change on the output side.
  - Input is still accepted while `In_Ready` = 1 (fills the skid entry when SKID = 1).
- `Occupancy` = 0 / 1 / 2 for EMPTY / FULL / SKID_FULL, registered with the state.
- Ordering: FIFO. The skid entry is always older than any new input; no entry is lost or duplicated.
- Widths: payload is passed through unmodified. No arithmetic is performed.

Test Plan:
- Reset then stream: Rst_n low 2 cycles -> Out_Valid = 0, Instruction_out = 0, In_Ready = 1. Push 0x00A00093/PC 0x4 with Out_Ready = 1 -> next cycle Out_Valid = 1, Instruction_out = 0x00A00093, PC_out = 0x4.
- Backpressure fill (SKID = 1): Out_Ready = 0, push 0x11 (PC 0x8) then 0x22 (PC 0xC) -> Occupancy 1 then 2, In_Ready = 0. Out_Ready = 1 -> pops 0x11, then 0x22, then Occupancy = 0.
- Stall hold: FULL with 0x33/PC 0x10, Stall = 1 and Out_Ready = 1 for 3 cycles -> outputs unchanged, no pop. Stall = 0 -> single pop.
- Flush in SKID_FULL with In_Valid = 1, PC_in = 0x40 -> next cycle Out_Valid = 0, Instruction_out = NOP_VALUE, PC_out = 0x40, Occupancy = 0, In_Ready = 1, flush-cycle input not delivered.
- Flush & Stall same cycle -> identical result to flush alone.
- SKID = 0, Out_Ready toggling every cycle with continuous input 1, 2, 3, … -> In_Ready follows the formula combinationally; output sequence is gap-free in order with no duplicates.
- Async reset asserted mid-cycle while in SKID_FULL -> outputs go to reset values immediately, without waiting for a Clk edge.
